// File: rtl/seq_write_master.sv
// Command sequencer: replays delay/write/jump/halt words from a command memory as AW/W/B write transactions.
// Optional macro SEQ_BRESP_CHECK_EN: a non-OKAY BRESP aborts the program and sets the sticky err flag.
module seq_write_master #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 7,
    parameter int MEM_AW    = 9,
    parameter int DLY_SHIFT = 19,
    localparam int CMD_W    = 2 + ADDR_W + DATA_W
) (
    input  logic              clk,
    input  logic              ARESETn,
    input  logic              start,
    input  logic              stop,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [CMD_W-1:0]  mem_rdata,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic              BVALID,
    output logic              BREADY,
    input  logic [1:0]        BRESP,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;
    localparam logic [2:0] S_DELAY  = 3'd5;

    localparam logic [1:0] OPC_DELAY = 2'b00;
    localparam logic [1:0] OPC_WRITE = 2'b01;
    localparam logic [1:0] OPC_JUMP  = 2'b10;
    localparam logic [1:0] OPC_HALT  = 2'b11;

    localparam int CNT_W = DATA_W + DLY_SHIFT;
    localparam logic [MEM_AW-1:0] PC_ONE  = MEM_AW'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [MEM_AW-1:0] pc;
    logic [CNT_W-1:0]  cnt;

    logic [1:0]        cmd_opc;
    logic [ADDR_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_d;
    logic [MEM_AW-1:0] jump_target;

    logic aw_fin;
    logic w_fin;
    logic b_fire;
    logic bresp_bad;

    assign {cmd_opc, cmd_a, cmd_d} = mem_rdata;
    assign jump_target = MEM_AW'({cmd_a, cmd_d});
    assign mem_addr    = pc;

    // A channel counts as finished once its VALID has dropped or its handshake lands this edge.
    assign aw_fin = !AWVALID || AWREADY;
    assign w_fin  = !WVALID || WREADY;
    assign b_fire = BVALID && BREADY;

`ifdef SEQ_BRESP_CHECK_EN
    assign bresp_bad = (BRESP != 2'b00);
`else
    logic bresp_unused;
    assign bresp_bad    = 1'b0;
    assign bresp_unused = ^BRESP;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH:  state_next = stop ? S_IDLE : S_DECODE;
            S_DECODE: begin
                case (cmd_opc)
                    OPC_DELAY: state_next = (cmd_d == '0) ? S_FETCH : S_DELAY;
                    OPC_WRITE: state_next = S_WRITE;
                    OPC_JUMP:  state_next = S_FETCH;
                    OPC_HALT:  state_next = S_IDLE;
                    default:   state_next = S_IDLE;
                endcase
            end
            S_WRITE:  if (aw_fin && w_fin) state_next = S_RESP;
            S_RESP:   if (b_fire) state_next = bresp_bad ? S_IDLE : S_FETCH;
            S_DELAY: begin
                if (stop)                state_next = S_IDLE;
                else if (cnt == CNT_ONE) state_next = S_FETCH;
            end
            default:  state_next = S_IDLE;
        endcase
    end

    // busy and done are registered from the next state so both change on the edge that enters IDLE.
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) begin
            state   <= S_IDLE;
            pc      <= '0;
            cnt     <= '0;
            AWADDR  <= '0;
            WDATA   <= '0;
            AWVALID <= 1'b0;
            WVALID  <= 1'b0;
            BREADY  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
            done  <= (state != S_IDLE) && (state_next == S_IDLE);
            case (state)
                S_IDLE: if (start) pc <= '0;
                S_DECODE: begin
                    case (cmd_opc)
                        OPC_DELAY: begin
                            cnt <= CNT_W'(cmd_d) << DLY_SHIFT;
                            if (cmd_d == '0) pc <= pc + PC_ONE;
                        end
                        OPC_WRITE: begin
                            AWADDR  <= cmd_a;
                            WDATA   <= cmd_d;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                        end
                        OPC_JUMP: pc <= jump_target;
                        default: ;
                    endcase
                end
                S_WRITE: begin
                    if (AWVALID && AWREADY) AWVALID <= 1'b0;
                    if (WVALID && WREADY)   WVALID  <= 1'b0;
                    if (aw_fin && w_fin)    BREADY  <= 1'b1;
                end
                S_RESP: begin
                    if (b_fire) begin
                        BREADY <= 1'b0;
                        if (!bresp_bad) pc <= pc + PC_ONE;
                    end
                end
                S_DELAY: begin
                    if (stop) begin
                        cnt <= '0;
                    end else if (cnt == CNT_ONE) begin
                        cnt <= '0;
                        pc  <= pc + PC_ONE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_BRESP_CHECK_EN
    // err survives the abort to IDLE and is only cleared by a fresh start.
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) begin
            err <= 1'b0;
        end else if (state == S_IDLE && start) begin
            err <= 1'b0;
        end else if (state == S_RESP && b_fire && bresp_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_write_master.sv
// Scoreboard bench for seq_write_master: expected AW/W beats are queued per program and popped on handshakes.
module tb_seq_write_master;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 7;
    localparam int MEM_AW    = 9;
    localparam int DLY_SHIFT = 2;
    localparam int CMD_W     = 2 + ADDR_W + DATA_W;
    localparam int MEM_DEPTH = 1 << MEM_AW;

    localparam logic [1:0] OPC_DELAY = 2'b00;
    localparam logic [1:0] OPC_WRITE = 2'b01;
    localparam logic [1:0] OPC_HALT  = 2'b11;

    logic              clk     = 1'b0;
    logic              ARESETn = 1'b1;
    logic              start   = 1'b0;
    logic              stop    = 1'b0;
    logic [MEM_AW-1:0] mem_addr;
    logic [CMD_W-1:0]  mem_rdata = '0;
    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY = 1'b0;
    logic [DATA_W-1:0] WDATA;
    logic              WVALID;
    logic              WREADY = 1'b0;
    logic              BVALID = 1'b0;
    logic              BREADY;
    logic [1:0]        BRESP = 2'b00;
    logic              busy;
    logic              done;
    logic              err;

    seq_write_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MEM_AW(MEM_AW),
        .DLY_SHIFT(DLY_SHIFT)
    ) dut (
        .clk(clk),
        .ARESETn(ARESETn),
        .start(start),
        .stop(stop),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .AWADDR(AWADDR),
        .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .WDATA(WDATA),
        .WVALID(WVALID),
        .WREADY(WREADY),
        .BVALID(BVALID),
        .BREADY(BREADY),
        .BRESP(BRESP),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    logic [CMD_W-1:0] rom [MEM_DEPTH];
    always @(posedge clk) mem_rdata <= rom[mem_addr];

    int tests_run    = 0;
    int tests_failed = 0;

    int busy_cycles, done_cycles, aw_valid_cycles, w_valid_cycles, bready_cycles;
    int aw_first, aw_hs, w_hs, b_hs;
    int aw_lat = 0;
    int w_lat  = 0;
    int aw_wait = 0;
    int w_wait  = 0;

    logic [ADDR_W-1:0] aw_exp [$];
    logic [DATA_W-1:0] w_exp  [$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [CMD_W-1:0] mkCmd(input logic [1:0] opc, input logic [ADDR_W-1:0] a,
                                               input logic [DATA_W-1:0] d);
        return {opc, a, d};
    endfunction

    function automatic logic [CMD_W-1:0] mkJump(input int target);
        logic [ADDR_W+DATA_W-1:0] t;
        t = target[ADDR_W+DATA_W-1:0];
        return {2'b10, t};
    endfunction

    // Slave model: READY rises once VALID has been waiting longer than the latency; B follows both beats.
    always @(posedge clk) begin
        #1;
        aw_wait = AWVALID ? aw_wait + 1 : 0;
        w_wait  = WVALID  ? w_wait + 1  : 0;
        AWREADY = (aw_wait > aw_lat);
        WREADY  = (w_wait > w_lat);
        BVALID  = ARESETn && (((aw_hs < w_hs) ? aw_hs : w_hs) > b_hs);
    end

    always @(negedge clk) begin
        if (ARESETn) begin
            if (busy) busy_cycles++;
            if (done) done_cycles++;
            if (BREADY) begin
                bready_cycles++;
                if (BVALID) b_hs++;
            end
            if (AWVALID) begin
                aw_valid_cycles++;
                if (aw_first == 0) aw_first = busy_cycles;
                checkOutput("aw_expected", int'(aw_exp.size() != 0), 1);
                if (aw_exp.size() != 0) checkOutput("awaddr", AWADDR, aw_exp[0]);
                if (AWREADY) begin
                    aw_hs++;
                    if (aw_exp.size() != 0) void'(aw_exp.pop_front());
                end
            end
            if (WVALID) begin
                w_valid_cycles++;
                checkOutput("w_expected", int'(w_exp.size() != 0), 1);
                if (w_exp.size() != 0) checkOutput("wdata", WDATA, w_exp[0]);
                if (WREADY) begin
                    w_hs++;
                    if (w_exp.size() != 0) void'(w_exp.pop_front());
                end
            end
        end
    end

    task automatic resetCounters();
        busy_cycles = 0; done_cycles = 0; aw_valid_cycles = 0; w_valid_cycles = 0;
        bready_cycles = 0; aw_first = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
    endtask

    task automatic clearRom();
        for (int i = 0; i < MEM_DEPTH; i++) rom[i] = mkCmd(OPC_HALT, '0, '0);
    endtask

    task automatic expectWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        aw_exp.push_back(a);
        w_exp.push_back(d);
    endtask

    task automatic pulseStart();
        resetCounters();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk); #1;
            seen = (done_cycles > 0);
        end
        checkOutput("done_within_budget", seen, 1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int budget);
        pulseStart();
        waitDone(budget);
    endtask

    task automatic checkQueues();
        checkOutput("aw_queue_drained", aw_exp.size(), 0);
        checkOutput("w_queue_drained", w_exp.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clearRom();
        #2 ARESETn = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_awaddr", AWADDR, 0);
        checkOutput("rst_wdata", WDATA, 0);
        checkOutput("rst_awvalid", AWVALID, 0);
        checkOutput("rst_wvalid", WVALID, 0);
        checkOutput("rst_bready", BREADY, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        ARESETn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_busy", busy, 0);

        // Single write then halt, all channels ready at once.
        rom[0] = mkCmd(OPC_WRITE, 4'd3, 7'h55);
        expectWrite(4'd3, 7'h55);
        applyStimulus(50);
        checkOutput("w1_aw_first", aw_first, 3);
        checkOutput("w1_aw_cycles", aw_valid_cycles, 1);
        checkOutput("w1_w_cycles", w_valid_cycles, 1);
        checkOutput("w1_bready_cycles", bready_cycles, 1);
        checkOutput("w1_b_hs", b_hs, 1);
        checkOutput("w1_busy_cycles", busy_cycles, 6);
        checkOutput("w1_done_pulses", done_cycles, 1);
        checkOutput("w1_busy_after", busy, 0);
        checkQueues();

        // AW ready late, W immediate.
        aw_lat = 3;
        expectWrite(4'd3, 7'h55);
        applyStimulus(50);
        checkOutput("w2_aw_cycles", aw_valid_cycles, 4);
        checkOutput("w2_w_cycles", w_valid_cycles, 1);
        checkOutput("w2_bready_cycles", bready_cycles, 1);
        checkOutput("w2_busy_cycles", busy_cycles, 9);
        checkQueues();
        aw_lat = 0;

        // W ready late, AW immediate.
        w_lat = 2;
        expectWrite(4'd3, 7'h55);
        applyStimulus(50);
        checkOutput("w3_aw_cycles", aw_valid_cycles, 1);
        checkOutput("w3_w_cycles", w_valid_cycles, 3);
        checkOutput("w3_b_hs", b_hs, 1);
        checkOutput("w3_busy_cycles", busy_cycles, 8);
        checkQueues();
        w_lat = 0;

        // Delay of 5 quanta (20 cycles) and a zero delay.
        clearRom();
        rom[0] = mkCmd(OPC_DELAY, '0, 7'd5);
        applyStimulus(100);
        checkOutput("d5_busy_cycles", busy_cycles, 24);
        checkOutput("d5_done_pulses", done_cycles, 1);
        checkOutput("d5_aw_cycles", aw_valid_cycles, 0);
        rom[0] = mkCmd(OPC_DELAY, '0, 7'd0);
        applyStimulus(50);
        checkOutput("d0_busy_cycles", busy_cycles, 4);

        // Stop raised during a write: transaction completes, next fetch ends the program.
        clearRom();
        aw_lat = 2;
        rom[0] = mkCmd(OPC_WRITE, 4'd5, 7'h2A);
        rom[1] = mkJump(0);
        expectWrite(4'd5, 7'h2A);
        pulseStart();
        for (int i = 0; i < 50 && aw_valid_cycles == 0; i++) begin @(negedge clk); #1; end
        checkOutput("sw_aw_seen", int'(aw_valid_cycles > 0), 1);
        stop = 1'b1;
        waitDone(50);
        stop = 1'b0;
        checkOutput("sw_aw_hs", aw_hs, 1);
        checkOutput("sw_b_hs", b_hs, 1);
        checkOutput("sw_busy_cycles", busy_cycles, 7);
        checkOutput("sw_done_pulses", done_cycles, 1);
        checkQueues();
        aw_lat = 0;

        // Stop raised during a long delay ends it on the next edge.
        clearRom();
        rom[0] = mkCmd(OPC_DELAY, '0, 7'd100);
        pulseStart();
        for (int i = 0; i < 50 && busy_cycles < 8; i++) begin @(negedge clk); #1; end
        checkOutput("sd_in_delay", busy, 1);
        stop = 1'b1;
        @(negedge clk); #1;
        checkOutput("sd_busy", busy, 0);
        checkOutput("sd_done", done, 1);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("sd_done_pulses", done_cycles, 1);

        // pc wraps from the last word to 0.
        clearRom();
        rom[0]             = mkJump(MEM_DEPTH - 1);
        rom[MEM_DEPTH - 1] = mkCmd(OPC_WRITE, 4'd9, 7'h11);
        expectWrite(4'd9, 7'h11);
        pulseStart();
        for (int i = 0; i < 50 && b_hs == 0; i++) begin @(negedge clk); #1; end
        checkOutput("wrap_b_seen", int'(b_hs > 0), 1);
        @(negedge clk); #1;
        checkOutput("wrap_mem_addr", mem_addr, 0);
        stop = 1'b1;
        waitDone(20);
        stop = 1'b0;
        checkOutput("wrap_aw_hs", aw_hs, 1);
        checkQueues();

        // Reset asserted while VALIDs are pending.
        clearRom();
        aw_lat = 50;
        w_lat  = 50;
        rom[0] = mkCmd(OPC_WRITE, 4'd7, 7'h7F);
        expectWrite(4'd7, 7'h7F);
        pulseStart();
        for (int i = 0; i < 50 && aw_valid_cycles == 0; i++) begin @(negedge clk); #1; end
        checkOutput("mr_aw_seen", int'(aw_valid_cycles > 0), 1);
        ARESETn = 1'b0;
        #1;
        checkOutput("mr_awvalid", AWVALID, 0);
        checkOutput("mr_wvalid", WVALID, 0);
        checkOutput("mr_bready", BREADY, 0);
        checkOutput("mr_busy", busy, 0);
        aw_lat = 0;
        w_lat  = 0;
        aw_exp.delete();
        w_exp.delete();
        @(negedge clk);
        ARESETn = 1'b1;
        resetCounters();
        @(negedge clk);

        // Error response on the first write.
        clearRom();
        BRESP  = 2'b10;
        rom[0] = mkCmd(OPC_WRITE, 4'd1, 7'h01);
        rom[1] = mkCmd(OPC_WRITE, 4'd2, 7'h02);
`ifdef SEQ_BRESP_CHECK_EN
        expectWrite(4'd1, 7'h01);
        applyStimulus(60);
        checkOutput("be_err", err, 1);
        checkOutput("be_done_pulses", done_cycles, 1);
        checkOutput("be_aw_hs", aw_hs, 1);
        repeat (10) @(negedge clk);
        checkOutput("be_no_more_aw", aw_valid_cycles, 1);
        checkOutput("be_err_held", err, 1);
        checkQueues();
        BRESP = 2'b00;
        expectWrite(4'd1, 7'h01);
        expectWrite(4'd2, 7'h02);
        pulseStart();
        checkOutput("be_err_cleared", err, 0);
        waitDone(60);
        checkOutput("be_rerun_aw_hs", aw_hs, 2);
        checkQueues();
`else
        expectWrite(4'd1, 7'h01);
        expectWrite(4'd2, 7'h02);
        applyStimulus(60);
        checkOutput("be_err", err, 0);
        checkOutput("be_aw_hs", aw_hs, 2);
        checkOutput("be_b_hs", b_hs, 2);
        checkOutput("be_done_pulses", done_cycles, 1);
        checkQueues();
        BRESP = 2'b00;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
